// File: rtl/winocnn_pkg.sv
// Shared types and constants for the Winograd CNN datapath.
// Result tiles, result packets and a round-robin helper.
package winocnn_pkg;

    localparam int TILE_DIM = 6;
    localparam int RES_W    = 12;
    localparam int ADDR_W   = 12;
    localparam int TILE_W   = TILE_DIM * TILE_DIM * RES_W;

    typedef logic [TILE_W-1:0] result_tile_t;

    typedef struct packed {
        result_tile_t      tile;
        logic [ADDR_W-1:0] addr;
    } result_pkt_t;

    // Index following idx in a ring of n entries.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding one PE's pending results.
// A push is still accepted when full if an entry pops in the same cycle.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/pe_result_collector.sv
// Collects PE result tiles into per-PE FIFOs and round-robins them
// onto valid/ready output-memory write ports.
module pe_result_collector
    import winocnn_pkg::*;
#(
    parameter int NUM_PE     = 4,
    parameter int NUM_WR     = 2,
    parameter int TILE_DIM   = winocnn_pkg::TILE_DIM,
    parameter int RES_W      = winocnn_pkg::RES_W,
    parameter int ADDR_W     = winocnn_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_PE-1:0][TILE_DIM*TILE_DIM*RES_W-1:0] pe_result_tile_i,
    input  logic [NUM_PE-1:0][ADDR_W-1:0]               pe_result_addr_i,
    input  logic [NUM_PE-1:0]                           pe_result_valid_i,
    output logic [NUM_WR-1:0][TILE_DIM*TILE_DIM*RES_W-1:0] wr_tile_o,
    output logic [NUM_WR-1:0][ADDR_W-1:0]               wr_addr_o,
    output logic [NUM_WR-1:0]                           wr_valid_o,
    input  logic [NUM_WR-1:0]                           wr_ready_i,
    output logic [NUM_PE-1:0]                           overflow_o,
    output logic                                        drained_o
);

    localparam int TW    = TILE_DIM * TILE_DIM * RES_W;
    localparam int PW    = TW + ADDR_W;
    localparam int M     = NUM_PE / NUM_WR;
    localparam int RR_W  = (M > 1) ? $clog2(M) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_PE-1:0][PW-1:0]    in_pkt;
    logic [NUM_PE-1:0][PW-1:0]    head_pkt;
    logic [NUM_PE-1:0][CNT_W-1:0] fifo_count;
    logic [NUM_PE-1:0]            fifo_full;
    logic [NUM_PE-1:0]            fifo_empty;
    logic [NUM_PE-1:0]            fifo_push;
    logic [NUM_PE-1:0]            fifo_pop;
    logic [NUM_PE-1:0]            grant;
    logic [NUM_PE-1:0]            overflow_q, overflow_d;
    logic                         drained_q, drained_d;

    for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
        assign in_pkt[p] = {pe_result_tile_i[p], pe_result_addr_i[p]};

        result_fifo #(
            .WIDTH (PW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (fifo_push[p]),
            .pop_i   (fifo_pop[p]),
            .data_i  (in_pkt[p]),
            .data_o  (head_pkt[p]),
            .full_o  (fifo_full[p]),
            .empty_o (fifo_empty[p]),
            .count_o (fifo_count[p])
        );
    end

    // A granted PE with an empty FIFO bypasses it straight into the port
    // register; a full FIFO that is not popped drops the incoming result.
    always_comb begin
        overflow_d = overflow_q;
        fifo_pop   = '0;
        fifo_push  = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            fifo_pop[p]  = grant[p] && !fifo_empty[p];
            fifo_push[p] = pe_result_valid_i[p] && !(grant[p] && fifo_empty[p]);
            if (pe_result_valid_i[p] && fifo_full[p] && !fifo_pop[p]) begin
                overflow_d[p] = 1'b1;
            end
        end
    end

    // Drained means nothing buffered and no write outstanding.
    always_comb begin
        drained_d = ~|wr_valid_o;
        for (int p = 0; p < NUM_PE; p++) begin
            if (fifo_count[p] != '0) drained_d = 1'b0;
        end
    end

    // Sticky overflow and registered drained flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= '0;
            drained_q  <= 1'b1;
        end else begin
            overflow_q <= overflow_d;
            drained_q  <= drained_d;
        end
    end

    assign overflow_o = overflow_q;
    assign drained_o  = drained_q;

    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
        logic [M-1:0]         avail;
        logic [M-1:0]         gnt;
        logic [M-1:0][PW-1:0] cand;
        logic [RR_W-1:0]      rr_q, rr_d;
        logic [RR_W-1:0]      sel;
        logic [RR_W-1:0]      idx;
        logic                 found;
        logic                 load;
        logic                 vld_q, vld_d;
        logic [PW-1:0]        pkt_q, pkt_d;

        for (genvar j = 0; j < M; j++) begin : g_map
            localparam int P = k + j * NUM_WR;
            assign avail[j] = !fifo_empty[P] || pe_result_valid_i[P];
            assign cand[j]  = fifo_empty[P] ? in_pkt[P] : head_pkt[P];
            assign grant[P] = gnt[j];
        end

        // Pick the first available PE at or after the RR pointer and
        // load it whenever the register is empty or transferring.
        always_comb begin
            gnt   = '0;
            rr_d  = rr_q;
            vld_d = vld_q;
            pkt_d = pkt_q;
            sel   = '0;
            idx   = '0;
            found = 1'b0;
            load  = !vld_q || wr_ready_i[k];
            if (load) begin
                for (int i = M - 1; i >= 0; i--) begin
                    idx = RR_W'((int'(rr_q) + i) % M);
                    if (avail[idx]) begin
                        found = 1'b1;
                        sel   = idx;
                    end
                end
                vld_d = found;
                if (found) begin
                    gnt[sel] = 1'b1;
                    pkt_d    = cand[sel];
                    rr_d     = RR_W'(rr_next(int'(sel), M));
                end
            end
        end

        // Output register and round-robin pointer.
        always_ff @(posedge clk) begin
            if (reset) begin
                rr_q  <= '0;
                vld_q <= 1'b0;
                pkt_q <= '0;
            end else begin
                rr_q  <= rr_d;
                vld_q <= vld_d;
                pkt_q <= pkt_d;
            end
        end

        assign wr_valid_o[k] = vld_q;
        assign wr_tile_o[k]  = pkt_q[PW-1:ADDR_W];
        assign wr_addr_o[k]  = pkt_q[ADDR_W-1:0];
    end

endmodule

// File: tb/tb_pe_result_collector.sv
// Directed and constrained-random bench for pe_result_collector.
// Instance a: 4 PEs / 2 ports; instance b: 8 PEs / 2 ports.
module tb_pe_result_collector;
    import winocnn_pkg::*;

    localparam int TW = TILE_W;

    typedef logic [11:0] aq_t [$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [3:0][TW-1:0] a_tile;
    logic [3:0][11:0]   a_addr;
    logic [3:0]         a_vld;
    logic [1:0][TW-1:0] a_wtile;
    logic [1:0][11:0]   a_waddr;
    logic [1:0]         a_wvld;
    logic [1:0]         a_rdy;
    logic [3:0]         a_ovf;
    logic               a_drn;

    logic [7:0][TW-1:0] b_tile;
    logic [7:0][11:0]   b_addr;
    logic [7:0]         b_vld;
    logic [1:0][TW-1:0] b_wtile;
    logic [1:0][11:0]   b_waddr;
    logic [1:0]         b_wvld;
    logic [1:0]         b_rdy;
    logic [7:0]         b_ovf;
    logic               b_drn;

    int total = 0;
    int bad   = 0;

    aq_t exp_q [8];
    int  outst [8];
    int  seqn  [8];

    result_tile_t t2_exp;

    pe_result_collector #(
        .NUM_PE(4), .NUM_WR(2), .TILE_DIM(6), .RES_W(12),
        .ADDR_W(12), .FIFO_DEPTH(4)
    ) u_a (
        .clk               (clk),
        .reset             (reset),
        .pe_result_tile_i  (a_tile),
        .pe_result_addr_i  (a_addr),
        .pe_result_valid_i (a_vld),
        .wr_tile_o         (a_wtile),
        .wr_addr_o         (a_waddr),
        .wr_valid_o        (a_wvld),
        .wr_ready_i        (a_rdy),
        .overflow_o        (a_ovf),
        .drained_o         (a_drn)
    );

    pe_result_collector #(
        .NUM_PE(8), .NUM_WR(2), .TILE_DIM(6), .RES_W(12),
        .ADDR_W(12), .FIFO_DEPTH(4)
    ) u_b (
        .clk               (clk),
        .reset             (reset),
        .pe_result_tile_i  (b_tile),
        .pe_result_addr_i  (b_addr),
        .pe_result_valid_i (b_vld),
        .wr_tile_o         (b_wtile),
        .wr_addr_o         (b_waddr),
        .wr_valid_o        (b_wvld),
        .wr_ready_i        (b_rdy),
        .overflow_o        (b_ovf),
        .drained_o         (b_drn)
    );

    task automatic chk(input string tag, input logic [TW-1:0] obs,
                       input logic [TW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic result_tile_t mk_tile(input int seed);
        result_tile_t t;
        t = '0;
        for (int e = 0; e < TILE_DIM * TILE_DIM; e++) begin
            t[e*RES_W +: RES_W] = RES_W'(seed * 7 + e);
        end
        return t;
    endfunction

    // Scoreboard: score the transfers that the coming edge will perform.
    task automatic scan_b();
        logic [11:0] ad;
        logic [11:0] ex;
        int          p;
        for (int k = 0; k < 2; k++) begin
            if (b_wvld[k] && b_rdy[k]) begin
                ad = b_waddr[k];
                p  = int'(ad[11:9]);
                chk("t6_port", TW'(p % 2), TW'(k));
                chk("t6_expected", TW'(exp_q[p].size() != 0), 1);
                if (exp_q[p].size() != 0) begin
                    ex = exp_q[p].pop_front();
                    outst[p]--;
                    chk("t6_addr", TW'(ad), TW'(ex));
                    chk("t6_tile", b_wtile[k], mk_tile(int'(ex)));
                end
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        a_vld  = '0;
        a_tile = '0;
        a_addr = '0;
        a_rdy  = '0;
        b_vld  = '0;
        b_tile = '0;
        b_addr = '0;
        b_rdy  = '0;
        for (int p = 0; p < 8; p++) begin
            outst[p] = 0;
            seqn[p]  = 0;
        end

        step();
        chk("rst_valid", TW'(a_wvld), 0);
        chk("rst_ovf", TW'(a_ovf), 0);
        chk("rst_drained", TW'(a_drn), 1);
        chk("rst_addr", TW'(a_waddr), 0);
        chk("rst_tile", a_wtile[0], '0);

        // mid-stream reset with data buffered and overflow set
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_vld = 4'hF;
            for (int p = 0; p < 4; p++) a_addr[p] = 12'(p * 16 + i);
            step();
        end
        a_vld = '0;
        chk("t1_ovf_pre", TW'(a_ovf), 4'hF);
        chk("t1_vld_pre", TW'(a_wvld), 2'b11);
        reset = 1'b1;
        a_rdy = 2'b11;
        step();
        chk("t1_vld", TW'(a_wvld), 0);
        chk("t1_ovf", TW'(a_ovf), 0);
        chk("t1_drained", TW'(a_drn), 1);
        reset = 1'b0;
        step();
        chk("t1_vld_after", TW'(a_wvld), 0);
        chk("t1_drained_after", TW'(a_drn), 1);

        // single result, bypass latency of one cycle
        t2_exp        = '0;
        t2_exp[11:0]  = 12'hFFB;
        a_tile[0]     = '0;
        a_tile[0][11:0] = 12'hFFB;
        a_addr[0]     = 12'h021;
        a_vld         = 4'b0001;
        step();
        a_vld = '0;
        chk("t2_vld", TW'(a_wvld), 2'b01);
        chk("t2_addr", TW'(a_waddr[0]), 12'h021);
        chk("t2_tile", a_wtile[0], t2_exp);
        step();
        chk("t2_vld_drop", TW'(a_wvld), 0);
        chk("t2_drained_lo", TW'(a_drn), 0);
        step();
        chk("t2_drained_hi", TW'(a_drn), 1);

        // fairness: PE0 and PE2 push every cycle for 9 cycles
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            a_vld     = (i < 9) ? 4'b0101 : 4'b0000;
            a_addr[0] = 12'(i);
            a_addr[2] = 12'(512 + i);
            step();
            chk("t3_vld", TW'(a_wvld[0]), 1);
            chk("t3_addr", TW'(a_waddr[0]),
                (i % 2 == 0) ? TW'(i / 2) : TW'(512 + i / 2));
            if (i == 7) chk("t3_ovf_none", TW'(a_ovf), 0);
            if (i == 8) chk("t3_ovf_pe2", TW'(a_ovf), 4'b0100);
        end
        a_vld = '0;
        step();
        chk("t3_vld_end", TW'(a_wvld[0]), 0);
        chk("t3_ovf_sticky", TW'(a_ovf), 4'b0100);

        // backpressure on port 1: six results from PE1, one dropped
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_rdy = 2'b01;
        for (int i = 0; i < 10; i++) begin
            a_vld     = (i < 6) ? 4'b0010 : 4'b0000;
            a_addr[1] = 12'(256 + i);
            a_tile[1] = mk_tile(i + 1);
            step();
            chk("t4_hold_vld", TW'(a_wvld[1]), 1);
            chk("t4_hold_addr", TW'(a_waddr[1]), 12'h100);
            chk("t4_hold_tile", a_wtile[1], mk_tile(1));
            if (i == 4) chk("t4_ovf_none", TW'(a_ovf), 0);
            if (i == 5) chk("t4_ovf_pe1", TW'(a_ovf), 4'b0010);
        end
        a_vld = '0;
        a_rdy = 2'b11;
        for (int j = 1; j < 5; j++) begin
            step();
            chk("t4_drain_vld", TW'(a_wvld[1]), 1);
            chk("t4_drain_addr", TW'(a_waddr[1]), TW'(256 + j));
            chk("t4_drain_tile", a_wtile[1], mk_tile(j + 1));
        end
        step();
        chk("t4_vld_end", TW'(a_wvld[1]), 0);

        // FIFO3 full, pop and push in the same cycle
        reset = 1'b1;
        step();
        reset = 1'b0;
        a_rdy = 2'b01;
        for (int i = 0; i < 5; i++) begin
            a_vld     = 4'b1000;
            a_addr[3] = 12'(768 + i);
            a_tile[3] = mk_tile(40 + i);
            step();
        end
        chk("t5_ovf_pre", TW'(a_ovf), 0);
        chk("t5_reg_addr", TW'(a_waddr[1]), 12'h300);
        a_rdy     = 2'b11;
        a_addr[3] = 12'h305;
        a_tile[3] = mk_tile(45);
        a_vld     = 4'b1000;
        step();
        a_vld = '0;
        chk("t5_ovf", TW'(a_ovf), 0);
        chk("t5_addr1", TW'(a_waddr[1]), 12'h301);
        for (int j = 2; j < 6; j++) begin
            step();
            chk("t5_addr", TW'(a_waddr[1]), TW'(768 + j));
            chk("t5_tile", a_wtile[1], mk_tile(40 + j));
        end
        step();
        chk("t5_vld_end", TW'(a_wvld[1]), 0);

        // random stress on the 8-PE instance
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            b_rdy = 2'($urandom_range(0, 3));
            scan_b();
            for (int p = 0; p < 8; p++) begin
                if (outst[p] < 4 && $urandom_range(0, 2) == 0) begin
                    b_vld[p]  = 1'b1;
                    b_addr[p] = 12'((p << 9) | (seqn[p] & 511));
                    b_tile[p] = mk_tile(int'(b_addr[p]));
                    exp_q[p].push_back(b_addr[p]);
                    outst[p]++;
                    seqn[p]++;
                end else begin
                    b_vld[p] = 1'b0;
                end
            end
            step();
        end
        b_vld = '0;
        b_rdy = 2'b11;
        for (int c = 0; c < 40; c++) begin
            scan_b();
            step();
        end
        for (int p = 0; p < 8; p++) begin
            chk("t6_leftover", TW'(exp_q[p].size()), 0);
        end
        chk("t6_ovf", TW'(b_ovf), 0);
        chk("t6_drained", TW'(b_drn), 1);
        chk("t6_vld_end", TW'(b_wvld), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
